// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin arbiter sharing the UDP transmit port of the
// Ethernet core between two packet builders (0 = RTP audio, 1 = control).
// The winner's payload/length are latched, the send handshake is driven,
// an inter-frame gap is enforced and a stalled core is recovered by timeout.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/data/length   requester N frame (valid level-held until ack/err)
//   reqN_ack / reqN_err      one-cycle completion / rejection pulses
//   udp_send_data_valid      frame request to the core
//   udp_send_data(_length)   latched payload and byte length
//   udp_send_data_ready      one-cycle completion pulse from the core
//   grant                    one-hot owner of the current frame, 00 when none
//   busy                     high whenever the arbiter is not idle
module udp_tx_arbiter #(
  parameter int unsigned DATA_W     = 7680,
  parameter int unsigned MAX_LEN    = 960,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [15:0]       req0_length,
  output logic              req0_ack,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [15:0]       req1_length,
  output logic              req1_ack,
  output logic              req1_err,
  output logic              udp_send_data_valid,
  output logic [DATA_W-1:0] udp_send_data,
  output logic [15:0]       udp_send_data_length,
  input  logic              udp_send_data_ready,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned TO_W  = 24;
  localparam int unsigned GAP_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic [1:0]          r_grant;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic [LEN_W-1:0]    r_len;
  logic [1:0]          r_ack;
  logic [1:0]          r_err;
  logic                r_busy;
  logic [TO_W-1:0]     r_to_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;

  state_t              w_state_nxt;
  logic                w_last_nxt;
  logic [1:0]          w_grant_nxt;
  logic                w_valid_nxt;
  logic [1:0]          w_ack_nxt;
  logic [1:0]          w_err_nxt;
  logic [TO_W-1:0]     w_to_nxt;
  logic [GAP_W-1:0]    w_gap_nxt;
  logic                w_load;
  logic                w_sel;
  logic [1:0]          w_sel_oh;
  logic [LEN_W-1:0]    w_sel_len;
  logic                w_len_bad;

  // Round-robin pick: on contention serve the requester not served last.
  assign w_sel     = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_sel_oh  = w_sel ? 2'b10 : 2'b01;
  assign w_sel_len = w_sel ? req1_length : req0_length;
  assign w_len_bad = (w_sel_len == '0) || (32'(w_sel_len) > MAX_LEN);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_ack_nxt   = 2'b00;
    w_err_nxt   = 2'b00;
    w_to_nxt    = r_to_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0_valid | req1_valid) begin
          w_last_nxt  = w_sel;
          w_grant_nxt = w_sel_oh;
          if (w_len_bad) begin
            w_err_nxt   = w_sel_oh;
            w_gap_nxt   = '0;
            w_state_nxt = GAP;
          end else begin
            w_load      = 1'b1;
            w_valid_nxt = 1'b1;
            w_to_nxt    = '0;
            w_state_nxt = SEND;
          end
        end
      end
      SEND: begin
        // Ready has priority over a simultaneous timeout expiry.
        if (udp_send_data_ready) begin
          w_valid_nxt = 1'b0;
          w_ack_nxt   = r_grant;
          w_gap_nxt   = '0;
          w_state_nxt = GAP;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_valid_nxt = 1'b0;
          w_err_nxt   = r_grant;
          w_gap_nxt   = '0;
          w_state_nxt = GAP;
        end else if (r_to_cnt != '1) begin
          w_to_nxt = r_to_cnt + TO_W'(1);
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          w_grant_nxt = 2'b00;
          w_state_nxt = IDLE;
        end else if (r_gap_cnt != '1) begin
          w_gap_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_grant_nxt = 2'b00;
        w_valid_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, control and payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_grant   <= 2'b00;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_len     <= '0;
      r_ack     <= 2'b00;
      r_err     <= 2'b00;
      r_busy    <= 1'b0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_valid   <= w_valid_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_to_cnt  <= w_to_nxt;
      r_gap_cnt <= w_gap_nxt;
      if (w_load) begin
        r_data <= w_sel ? req1_data : req0_data;
        r_len  <= w_sel_len;
      end
    end
  end

  assign req0_ack             = r_ack[0];
  assign req1_ack             = r_ack[1];
  assign req0_err             = r_err[0];
  assign req1_err             = r_err[1];
  assign udp_send_data_valid  = r_valid;
  assign udp_send_data        = r_data;
  assign udp_send_data_length = r_len;
  assign grant                = r_grant;
  assign busy                 = r_busy;

endmodule
